// File: rtl/iterative_divider.sv
// Multi-cycle restoring divider for RV64M DIV/DIVU/REM/REMU.
// One quotient bit per cycle; sign fix-up happens in a separate FINISH cycle.
module iterative_divider #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 7
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result
);

  // Handshake: a transfer happens on a rising edge where valid && ready are
  // both high; valid, once raised, holds its payload stable until that edge.

  typedef enum logic [1:0] {IDLE, RUN, FINISH, DONE} state_t;

  state_t            state_q, state_d;
  logic [1:0]        op_q;
  logic              sign_q, sign_r;
  logic [XLEN-1:0]   rem_q, quo_q, dvsr_q, result_q;
  logic [CNT_W-1:0]  cnt_q;

  logic              signed_op, a_neg, b_neg, div_zero, ovf, special;
  logic [XLEN-1:0]   a_abs, b_abs, special_result;
  logic [XLEN:0]     rem_shift;
  logic              ge;
  logic [XLEN-1:0]   rem_sub, q_fix, r_fix;

  // Operand decode, only meaningful while IDLE
  always_comb begin
    signed_op = ~op[0];
    a_neg     = signed_op & dividend[XLEN-1];
    b_neg     = signed_op & divisor[XLEN-1];
    a_abs     = a_neg ? (~dividend + 1'b1) : dividend;
    b_abs     = b_neg ? (~divisor + 1'b1) : divisor;
    div_zero  = (divisor == '0);
    ovf       = signed_op && (dividend == {1'b1, {(XLEN-1){1'b0}}}) && (divisor == '1);
    special   = div_zero | ovf;
    if (div_zero)
      special_result = op[1] ? dividend : '1;
    else
      special_result = op[1] ? '0 : dividend;
  end

  // Restoring step: the shifted remainder needs XLEN+1 bits before the compare,
  // but after a successful subtract it is below the divisor and fits XLEN bits.
  always_comb begin
    rem_shift = {rem_q, quo_q[XLEN-1]};
    ge        = (rem_shift >= {1'b0, dvsr_q});
    rem_sub   = rem_shift[XLEN-1:0] - dvsr_q;
    q_fix     = sign_q ? (~quo_q + 1'b1) : quo_q;
    r_fix     = sign_r ? (~rem_q + 1'b1) : rem_q;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = special ? DONE : RUN;
      RUN:     if (cnt_q == '0) state_d = FINISH;
      FINISH:  state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    result    = result_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= '0;
      sign_q   <= 1'b0;
      sign_r   <= 1'b0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvsr_q   <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else if (!flush) begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            op_q   <= op;
            sign_q <= a_neg ^ b_neg;
            sign_r <= a_neg;
            if (special) begin
              result_q <= special_result;
            end else begin
              rem_q  <= '0;
              quo_q  <= a_abs;
              dvsr_q <= b_abs;
              cnt_q  <= CNT_W'(XLEN - 1);
            end
          end
        end
        RUN: begin
          rem_q <= ge ? rem_sub : rem_shift[XLEN-1:0];
          quo_q <= {quo_q[XLEN-2:0], ge};
          if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
        end
        FINISH:  result_q <= op_q[1] ? r_fix : q_fix;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_iterative_divider.sv
// Directed bench for iterative_divider: signed/unsigned results, special cases,
// latency, back-pressure, flush and asynchronous reset.
module tb_iterative_divider;

  localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11;
  localparam int NORMAL_LAT  = 65;
  localparam int SPECIAL_LAT = 0;   // result visible right after the accept edge

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b1;
  logic [1:0]  op = '0;
  logic [63:0] dividend = '0;
  logic [63:0] divisor = '0;
  logic        in_ready, out_valid;
  logic [63:0] result;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  iterative_divider #(.XLEN(64), .CNT_W(7)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .dividend  (dividend),
    .divisor   (divisor),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Presents one request at a negedge; returns #1 after the accept edge.
  task automatic issue(input logic [1:0] o, input logic [63:0] a, input logic [63:0] b,
                       input string tag);
    @(negedge clk);
    check({tag, "_in_ready_pre"}, 64'(in_ready), 64'd1);
    op = o; dividend = a; divisor = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    op = 2'($urandom);
    dividend = {$urandom, $urandom};
    divisor  = {$urandom, $urandom};
    check({tag, "_in_ready_busy"}, 64'(in_ready), 64'd0);
  endtask

  // Counts edges after the accept edge until out_valid; consumes if out_ready.
  task automatic wait_result(input string tag, input int exp_lat, input logic [63:0] exp);
    int lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    check({tag, "_result"}, result, exp);
    if (out_ready) begin
      @(posedge clk); #1;
      check({tag, "_idle_after"}, {62'd0, out_valid, in_ready}, 64'b01);
    end
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_result", result, 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Unsigned
    issue(OP_DIVU, 64'd100, 64'd7, "divu_100_7");
    wait_result("divu_100_7", NORMAL_LAT, 64'd14);
    issue(OP_REMU, 64'd100, 64'd7, "remu_100_7");
    wait_result("remu_100_7", NORMAL_LAT, 64'd2);

    // Signed
    issue(OP_DIV, -64'sd7, 64'd2, "div_m7_2");
    wait_result("div_m7_2", NORMAL_LAT, 64'hFFFF_FFFF_FFFF_FFFD);
    issue(OP_REM, -64'sd7, 64'd2, "rem_m7_2");
    wait_result("rem_m7_2", NORMAL_LAT, 64'hFFFF_FFFF_FFFF_FFFF);
    issue(OP_REM, 64'd7, -64'sd2, "rem_7_m2");
    wait_result("rem_7_m2", NORMAL_LAT, 64'd1);
    issue(OP_DIV, 64'd7, -64'sd2, "div_7_m2");
    wait_result("div_7_m2", NORMAL_LAT, 64'hFFFF_FFFF_FFFF_FFFD);

    // Divide by zero
    issue(OP_DIVU, 64'd5, 64'd0, "divu_5_0");
    wait_result("divu_5_0", SPECIAL_LAT, 64'hFFFF_FFFF_FFFF_FFFF);
    issue(OP_REMU, 64'd5, 64'd0, "remu_5_0");
    wait_result("remu_5_0", SPECIAL_LAT, 64'd5);
    issue(OP_DIV, -64'sd5, 64'd0, "div_m5_0");
    wait_result("div_m5_0", SPECIAL_LAT, 64'hFFFF_FFFF_FFFF_FFFF);

    // Signed overflow
    issue(OP_DIV, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, "div_ovf");
    wait_result("div_ovf", SPECIAL_LAT, 64'h8000_0000_0000_0000);
    issue(OP_REM, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, "rem_ovf");
    wait_result("rem_ovf", SPECIAL_LAT, 64'd0);

    // Back-pressure
    out_ready = 1'b0;
    issue(OP_DIVU, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, "bp");
    wait_result("bp", NORMAL_LAT, 64'h5555_5555_5555_5555);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("bp_hold_result", result, 64'h5555_5555_5555_5555);
      check("bp_hold_flags", {62'd0, out_valid, in_ready}, 64'b10);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release", {62'd0, out_valid, in_ready}, 64'b01);

    // Flush at iteration 30
    issue(OP_DIVU, 64'd1000, 64'd9, "flush");
    repeat (30) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_idle", {62'd0, out_valid, in_ready}, 64'b01);
    begin
      logic seen = 1'b0;
      for (int i = 0; i < 80; i++) begin
        @(posedge clk); #1;
        seen = seen | out_valid;
      end
      check("flush_no_valid", 64'(seen), 64'd0);
    end

    // Async reset mid-RUN
    issue(OP_DIVU, 64'd77, 64'd5, "arst");
    repeat (20) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", 64'(out_valid), 64'd0);
    check("arst_result", result, 64'd0);
    check("arst_in_ready", 64'(in_ready), 64'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    begin
      logic seen = 1'b0;
      for (int i = 0; i < 70; i++) begin
        @(posedge clk); #1;
        seen = seen | out_valid;
      end
      check("arst_no_valid", 64'(seen), 64'd0);
    end
    issue(OP_DIVU, 64'd9, 64'd3, "divu_9_3");
    wait_result("divu_9_3", NORMAL_LAT, 64'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
